// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: latches edge events from three external peripherals and a machine timer,
// then presents at most one one-hot request line to the core, held until acknowledged by ID.
module irq_source_ctrl #(
    parameter int unsigned TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         ext_req,
    input  logic               ack_valid,
    input  logic [1:0]         ack_id,
    input  logic               mask_wr,
    input  logic [3:0]         mask_wdata,
    input  logic               tcmp_wr,
    input  logic [TIMER_W-1:0] tcmp_wdata,
    output logic [3:0]         interrupt,
    output logic [3:0]         pending,
    output logic [TIMER_W-1:0] mtime
);

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StGap
    } state_t;

    // External event synchronizer and edge detector
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_sync2_d;
    logic [2:0]         w_ext_rise;

    // Timer
    logic [TIMER_W-1:0] r_mtime;
    logic [TIMER_W-1:0] r_mtimecmp;
    logic               w_tmr_match;

    // Mask and pending bookkeeping
    logic [3:0]         r_mask;
    logic [3:0]         r_pending;
    logic [3:0]         w_pending_set;
    logic [3:0]         w_pending_clr;
    logic [3:0]         w_pending_next;
    logic [3:0]         w_eligible;

    // Arbitration and request FSM
    logic [1:0]         w_sel_id;
    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_cur_id;
    logic [1:0]         w_cur_id_next;
    logic [3:0]         r_interrupt;
    logic [3:0]         w_interrupt_next;
    logic               w_ack_clr;

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    // Clearing on reset means a line already high at release looks like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 3'b000;
            r_sync2   <= 3'b000;
            r_sync2_d <= 3'b000;
        end else begin
            r_sync1   <= ext_req;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign w_ext_rise = r_sync2 & ~r_sync2_d;

    // Free-running timer and its compare register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
        end else begin
            r_mtime <= r_mtime + TIMER_W'(1);
            if (tcmp_wr) begin
                r_mtimecmp <= tcmp_wdata;
            end
        end
    end

    // Match uses the compare value in effect this cycle, not one being written.
    assign w_tmr_match = (r_mtime == r_mtimecmp);

    // Enable mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= 4'b1111;
        end else if (mask_wr) begin
            r_mask <= mask_wdata;
        end
    end

    // Pending next-state: set sources win over clear sources on the same bit.
    always_comb begin
        w_pending_set = {w_ext_rise, w_tmr_match};
        w_pending_clr = {3'b000, tcmp_wr};
        if (w_ack_clr) begin
            w_pending_clr = w_pending_clr | (4'b0001 << r_cur_id);
        end
        w_pending_next = (r_pending & ~w_pending_clr) | w_pending_set;
    end

    // Pending register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 4'b0000;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign w_eligible = r_pending & r_mask;

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        w_sel_id = 2'd0;
        if (w_eligible[0]) begin
            w_sel_id = 2'd0;
        end else if (w_eligible[1]) begin
            w_sel_id = 2'd1;
        end else if (w_eligible[2]) begin
            w_sel_id = 2'd2;
        end else if (w_eligible[3]) begin
            w_sel_id = 2'd3;
        end
    end

    // FSM next-state, selected ID and request line.
    always_comb begin
        w_state_next     = r_state;
        w_cur_id_next    = r_cur_id;
        w_interrupt_next = r_interrupt;
        w_ack_clr        = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_interrupt_next = 4'b0000;
                if (|w_eligible) begin
                    w_cur_id_next    = w_sel_id;
                    w_interrupt_next = 4'b0001 << w_sel_id;
                    w_state_next     = StAssert;
                end
            end
            StAssert: begin
                // Line is held regardless of mask changes; only a matching ack drops it.
                if (ack_valid && (ack_id == r_cur_id)) begin
                    w_ack_clr        = 1'b1;
                    w_interrupt_next = 4'b0000;
                    w_state_next     = StGap;
                end
            end
            StGap: begin
                w_interrupt_next = 4'b0000;
                w_state_next     = StIdle;
            end
            default: begin
                w_interrupt_next = 4'b0000;
                w_state_next     = StIdle;
            end
        endcase
    end

    // FSM state, current ID and registered request output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cur_id    <= 2'd0;
            r_interrupt <= 4'b0000;
        end else begin
            r_state     <= w_state_next;
            r_cur_id    <= w_cur_id_next;
            r_interrupt <= w_interrupt_next;
        end
    end

    assign interrupt = r_interrupt;
    assign pending   = r_pending;
    assign mtime     = r_mtime;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Self-checking bench for irq_source_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_irq_source_ctrl;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2:0]    ext_req = 3'b000;
    logic          ack_valid = 1'b0;
    logic [1:0]    ack_id = 2'd0;
    logic          mask_wr = 1'b0;
    logic [3:0]    mask_wdata = 4'b0000;
    logic          tcmp_wr = 1'b0;
    logic [TW-1:0] tcmp_wdata = '0;
    logic [3:0]    interrupt;
    logic [3:0]    pending;
    logic [TW-1:0] mtime;

    int n_tests = 0;
    int n_fail  = 0;

    irq_source_ctrl #(.TIMER_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_req    (ext_req),
        .ack_valid  (ack_valid),
        .ack_id     (ack_id),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .tcmp_wr    (tcmp_wr),
        .tcmp_wdata (tcmp_wdata),
        .interrupt  (interrupt),
        .pending    (pending),
        .mtime      (mtime)
    );

    always #5 clk = ~clk;

    // Behavioural model: history of sampled ext_req, pending set, timer, and a simple
    // phase number (0 idle, 1 request raised, 2 gap) with the raised source index.
    logic [3:0]    m_pend;
    logic [3:0]    m_mask;
    logic [TW-1:0] m_mtime;
    logic [TW-1:0] m_cmp;
    logic [2:0]    m_h0, m_h1, m_h2;
    int            m_phase;
    int            m_cur;
    wire  [3:0]    m_int = (m_phase == 1) ? (4'b0001 << m_cur) : 4'b0000;

    always @(posedge clk or posedge rst) begin : model
        logic [3:0] set_v;
        logic [3:0] clr_v;
        logic [3:0] elig;
        int         nphase;
        int         ncur;
        if (rst) begin
            m_pend  <= 4'b0000;
            m_mask  <= 4'b1111;
            m_mtime <= '0;
            m_cmp   <= '1;
            m_h0    <= 3'b000;
            m_h1    <= 3'b000;
            m_h2    <= 3'b000;
            m_phase <= 0;
            m_cur   <= 0;
        end else begin
            // An event counts when seen high two samples ago and low three samples ago.
            set_v  = {m_h1 & ~m_h2, (m_mtime == m_cmp)};
            clr_v  = 4'b0000;
            if (tcmp_wr) clr_v[0] = 1'b1;
            nphase = m_phase;
            ncur   = m_cur;
            if (m_phase == 1) begin
                if (ack_valid && int'(ack_id) == m_cur) begin
                    clr_v[m_cur] = 1'b1;
                    nphase = 2;
                end
            end else if (m_phase == 2) begin
                nphase = 0;
            end else begin
                elig = m_pend & m_mask;
                for (int i = 3; i >= 0; i--) begin
                    if (elig[i]) begin
                        ncur   = i;
                        nphase = 1;
                    end
                end
            end
            m_pend  <= (m_pend & ~clr_v) | set_v;
            m_phase <= nphase;
            m_cur   <= ncur;
            m_mtime <= TW'((int'(m_mtime) + 1) % (1 << TW));
            if (tcmp_wr) m_cmp <= tcmp_wdata;
            if (mask_wr) m_mask <= mask_wdata;
            m_h2 <= m_h1;
            m_h1 <= m_h0;
            m_h0 <= ext_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ext_req   = 3'b000;
        ack_valid = 1'b0;
        mask_wr   = 1'b0;
        tcmp_wr   = 1'b0;
        rst       = 1'b0;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (interrupt !== 4'b0000) begin
            n_fail++; $display("FAIL reset_interrupt: got %b want 0000", interrupt);
        end
        n_tests++;
        if (pending !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pending: got %b want 0000", pending);
        end
        n_tests++;
        if (mtime !== '0) begin
            n_fail++; $display("FAIL reset_mtime: got %0d want 0", mtime);
        end
        tick();
        n_tests++;
        if (mtime !== TW'(1)) begin
            n_fail++; $display("FAIL mtime_step: got %0d want 1", mtime);
        end
    endtask

    task automatic test_single_ext();
        do_reset();
        ext_req = 3'b010;
        tick();
        tick();
        n_tests++;
        if (pending !== 4'b0000) begin
            n_fail++; $display("FAIL single_pend_e1: got %b want 0000", pending);
        end
        tick();
        n_tests++;
        if (pending !== 4'b0100 || interrupt !== 4'b0000) begin
            n_fail++; $display("FAIL single_pend_e2: got %b/%b want 0100/0000", pending, interrupt);
        end
        tick();
        n_tests++;
        if (interrupt !== 4'b0100) begin
            n_fail++; $display("FAIL single_irq_e3: got %b want 0100", interrupt);
        end
        ext_req   = 3'b000;
        ack_valid = 1'b1;
        ack_id    = 2'd2;
        tick();
        ack_valid = 1'b0;
        n_tests++;
        if (interrupt !== 4'b0000 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL single_ack: got %b/%b want 0000/0000", interrupt, pending);
        end
    endtask

    task automatic test_priority();
        do_reset();
        ext_req = 3'b101;
        tick();
        tick();
        ext_req = 3'b000;
        tick();
        n_tests++;
        if (pending !== 4'b1010) begin
            n_fail++; $display("FAIL prio_pend: got %b want 1010", pending);
        end
        tick();
        n_tests++;
        if (interrupt !== 4'b0010) begin
            n_fail++; $display("FAIL prio_first: got %b want 0010", interrupt);
        end
        ack_valid = 1'b1;
        ack_id    = 2'd1;
        tick();
        ack_valid = 1'b0;
        n_tests++;
        if (interrupt !== 4'b0000 || pending !== 4'b1000) begin
            n_fail++; $display("FAIL prio_ack: got %b/%b want 0000/1000", interrupt, pending);
        end
        tick();
        n_tests++;
        if (interrupt !== 4'b0000) begin
            n_fail++; $display("FAIL prio_gap: got %b want 0000", interrupt);
        end
        tick();
        n_tests++;
        if (interrupt !== 4'b1000) begin
            n_fail++; $display("FAIL prio_second: got %b want 1000", interrupt);
        end
    endtask

    task automatic test_timer();
        do_reset();
        tcmp_wr    = 1'b1;
        tcmp_wdata = TW'(10);
        tick();
        tcmp_wr = 1'b0;
        repeat (9) tick();
        n_tests++;
        if (pending !== 4'b0000 || mtime !== TW'(10)) begin
            n_fail++; $display("FAIL timer_e10: got %b/%0d want 0000/10", pending, mtime);
        end
        tick();
        n_tests++;
        if (pending !== 4'b0001 || interrupt !== 4'b0000) begin
            n_fail++; $display("FAIL timer_e11: got %b/%b want 0001/0000", pending, interrupt);
        end
        tick();
        n_tests++;
        if (interrupt !== 4'b0001) begin
            n_fail++; $display("FAIL timer_e12: got %b want 0001", interrupt);
        end
        tcmp_wr    = 1'b1;
        tcmp_wdata = TW'(100);
        tick();
        tcmp_wr = 1'b0;
        n_tests++;
        if (pending !== 4'b0000 || interrupt !== 4'b0001) begin
            n_fail++; $display("FAIL timer_cmpwr: got %b/%b want 0000/0001", pending, interrupt);
        end
        ack_valid = 1'b1;
        ack_id    = 2'd0;
        tick();
        ack_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (interrupt !== 4'b0000 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL timer_ack: got %b/%b want 0000/0000", interrupt, pending);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (255) tick();
        n_tests++;
        if (mtime !== TW'(255) || pending !== 4'b0000) begin
            n_fail++; $display("FAIL wrap_top: got %0d/%b want 255/0000", mtime, pending);
        end
        tick();
        n_tests++;
        if (mtime !== '0 || pending !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_zero: got %0d/%b want 0/0001", mtime, pending);
        end
        tick();
        n_tests++;
        if (interrupt !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_irq: got %b want 0001", interrupt);
        end
    endtask

    task automatic test_mask_and_acks();
        do_reset();
        mask_wr    = 1'b1;
        mask_wdata = 4'b1101;
        tick();
        mask_wr = 1'b0;
        ext_req = 3'b001;
        repeat (4) tick();
        ext_req = 3'b000;
        n_tests++;
        if (pending !== 4'b0010 || interrupt !== 4'b0000) begin
            n_fail++; $display("FAIL mask_block: got %b/%b want 0010/0000", pending, interrupt);
        end
        ack_valid = 1'b1;
        ack_id    = 2'd1;
        tick();
        ack_valid = 1'b0;
        n_tests++;
        if (pending !== 4'b0010) begin
            n_fail++; $display("FAIL idle_ack: got %b want 0010", pending);
        end
        mask_wr    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_wr = 1'b0;
        n_tests++;
        if (interrupt !== 4'b0000) begin
            n_fail++; $display("FAIL unmask_e0: got %b want 0000", interrupt);
        end
        tick();
        n_tests++;
        if (interrupt !== 4'b0010) begin
            n_fail++; $display("FAIL unmask_e1: got %b want 0010", interrupt);
        end
        ack_valid = 1'b1;
        ack_id    = 2'd3;
        tick();
        ack_valid = 1'b0;
        n_tests++;
        if (interrupt !== 4'b0010 || pending !== 4'b0010) begin
            n_fail++; $display("FAIL wrong_ack: got %b/%b want 0010/0010", interrupt, pending);
        end
        mask_wr    = 1'b1;
        mask_wdata = 4'b0000;
        tick();
        mask_wr = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (interrupt !== 4'b0010) begin
            n_fail++; $display("FAIL mask_hold: got %b want 0010", interrupt);
        end
        ack_valid = 1'b1;
        ack_id    = 2'd1;
        tick();
        ack_valid = 1'b0;
        n_tests++;
        if (interrupt !== 4'b0000 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL mask_ack: got %b/%b want 0000/0000", interrupt, pending);
        end
    endtask

    task automatic test_collision();
        do_reset();
        ext_req = 3'b010;
        repeat (4) tick();
        ext_req = 3'b000;
        repeat (3) tick();
        n_tests++;
        if (interrupt !== 4'b0100) begin
            n_fail++; $display("FAIL coll_setup: got %b want 0100", interrupt);
        end
        ext_req = 3'b010;
        tick();
        tick();
        ack_valid = 1'b1;
        ack_id    = 2'd2;
        tick();
        ack_valid = 1'b0;
        n_tests++;
        if (interrupt !== 4'b0000 || pending !== 4'b0100) begin
            n_fail++; $display("FAIL coll_set_wins: got %b/%b want 0000/0100", interrupt, pending);
        end
        tick();
        tick();
        n_tests++;
        if (interrupt !== 4'b0100) begin
            n_fail++; $display("FAIL coll_reraise: got %b want 0100", interrupt);
        end
        // Level still high: after this ack the bit must stay clear.
        ack_valid = 1'b1;
        ack_id    = 2'd2;
        tick();
        ack_valid = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (interrupt !== 4'b0000 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL level_no_reset: got %b/%b want 0000/0000", interrupt, pending);
        end
        ext_req = 3'b000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ext_req = 3'b010;
        repeat (4) tick();
        n_tests++;
        if (interrupt !== 4'b0100) begin
            n_fail++; $display("FAIL rstmid_setup: got %b want 0100", interrupt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (interrupt !== 4'b0000 || mtime !== '0 || pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b/%0d/%b want 0000/0/0000", interrupt, mtime, pending);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        n_tests++;
        if (pending !== 4'b0000) begin
            n_fail++; $display("FAIL rel_edge_e2: got %b want 0000", pending);
        end
        tick();
        n_tests++;
        if (pending !== 4'b0100) begin
            n_fail++; $display("FAIL rel_edge_e3: got %b want 0100", pending);
        end
        ext_req = 3'b000;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 700; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) ext_req[b] = ~ext_req[b];
            end
            ack_valid = ($urandom_range(0, 2) == 0);
            ack_id    = 2'($urandom_range(0, 3));
            mask_wr   = ($urandom_range(0, 19) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            tcmp_wr   = ($urandom_range(0, 29) == 0);
            tcmp_wdata = TW'(int'(m_mtime) + int'($urandom_range(2, 20)));
            tick();
            n_tests++;
            if (interrupt !== m_int || pending !== m_pend || mtime !== m_mtime) begin
                n_fail++;
                errs++;
                if (errs <= 5) begin
                    $display("FAIL random_c%0d: got int=%b pend=%b mtime=%0d want int=%b pend=%b mtime=%0d",
                             c, interrupt, pending, mtime, m_int, m_pend, m_mtime);
                end
            end
        end
        ext_req   = 3'b000;
        ack_valid = 1'b0;
        mask_wr   = 1'b0;
        tcmp_wr   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_ext();
        test_priority();
        test_timer();
        test_wrap();
        test_mask_and_acks();
        test_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_source_ctrl.md
# irq_source_ctrl

Interrupt source controller that drives the core's 4-bit `interrupt` input. It latches edge events from three external peripherals plus one internal machine timer, applies a per-source enable mask, and presents at most one one-hot request line to the core at a time. Each request is held until the core acknowledges it by ID. It sits between peripheral event wires and the processor top, alongside the data-memory bus.

## Interface
- `TIMER_W`, default 32: width of `mtime` and `mtimecmp`.
- `clk  in  1`: single clock.
- `rst  in  1`: asynchronous reset, active-high.
- `ext_req  in  3`: peripheral event lines. Bit k feeds source k+1. May be asynchronous to `clk`.
- `ack_valid  in  1`: one-cycle acknowledge strobe from the core.
- `ack_id  in  2`: source index being acknowledged.
- `mask_wr  in  1`: write strobe for the enable mask.
- `mask_wdata  in  4`: new enable mask. Bit i enables source i.
- `tcmp_wr  in  1`: write strobe for `mtimecmp`.
- `tcmp_wdata  in  TIMER_W`: new `mtimecmp` value.
- `interrupt  out  4`: one-hot or zero request to the core. Registered.
- `pending  out  4`: latched pending bits, visible regardless of mask.
- `mtime  out  TIMER_W`: free-running timer value.

## Operation
- Source 0 is the timer. Sources 1..3 are `ext_req[0..2]`. Priority is fixed: lowest index wins.
- External path:
  - Each `ext_req` bit passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync2_d).
  - A detected edge sets `pending[k+1]`.
  - Level-high without an edge does not re-set a cleared bit.
- Timer path:
  - `mtime` increments by 1 every cycle and wraps from all-ones to 0.
  - `mtimecmp` resets to all-ones.
  - When `mtime == mtimecmp`, `pending[0]` is set at the next edge.
  - A `tcmp_wr` clears `pending[0]` unless a match sets it in the same cycle; set wins.
- Mask:
  - The mask resets to 4'b1111. `mask_wr` loads `mask_wdata`.
  - Masked sources still latch pending bits but are not eligible for selection.
- FSM states IDLE, ASSERT, GAP:
  - IDLE: if `pending & mask` is nonzero, latch `cur_id` = highest-priority eligible index, drive `interrupt` = one-hot(`cur_id`) from the next edge, and go to ASSERT.
  - ASSERT: hold `interrupt` and `cur_id`. Masking or any other event does not retract the line. On `ack_valid && ack_id == cur_id`: clear `pending[cur_id]`, drive `interrupt` to 0 at the next edge, and go to GAP.
  - GAP: one cycle with `interrupt` = 0, then go to IDLE. Arbitration restarts in IDLE.
- Acks are ignored in IDLE or GAP, and when `ack_id != cur_id`.
- Ack clear and a new set of the same bit in the same cycle: set wins, so the bit stays pending and is re-raised after GAP.

## Timing
- All outputs come from flops. Reset values: `interrupt` = 0, `pending` = 0, `mtime` = 0, mask = 4'b1111, `mtimecmp` = all-ones, FSM = IDLE.
- External latency: with `ext_req` high before edge 0, sync1 captures it at edge 0, sync2 at edge 1, `pending` sets at edge 2, and `interrupt` asserts at edge 3 if the FSM is in IDLE.
- Timer latency: the match is seen in cycle n, `pending[0]` is set at edge n+1, and `interrupt[0]` asserts at edge n+2.
- Ack-to-drop: an ack sampled at edge m deasserts `interrupt` at edge m, leaves GAP at edge m+1, and the earliest next assertion is edge m+2.
- Reset asserted mid-operation forces all state to reset values immediately, regardless of the clock. The synchronizer flops also clear, so an `ext_req` already high at reset release produces an edge.

## Test plan
- Single external event: pulse `ext_req[1]` high before edge 0. Expect `pending` = 4'b0100 at edge 2 and `interrupt` = 4'b0100 at edge 3. Ack with id 2: `interrupt` = 0 on the next edge and `pending` = 0.
- Priority: set pending on sources 3 and 1 in the same cycle. Expect `interrupt` = 4'b0010 first. After ack id 1, expect one GAP cycle, then `interrupt` = 4'b1000.
- Timer: write `mtimecmp` = 10 after reset. Expect `pending[0]` at edge 11 and `interrupt` = 4'b0001 at edge 12. A `tcmp_wr` of 100 followed by ack id 0 clears it.
- Masking:
  - Write mask 4'b1101 and raise source 1. Expect `pending` = 4'b0010 and `interrupt` = 0.
  - Write mask 4'b1111. Expect `interrupt` = 4'b0010 two edges later.
  - Mask the asserted source during ASSERT. Expect the line held until ack.
- Wrong or idle ack: `ack_id` = 3 while `interrupt` = 4'b0010 leaves it unchanged. An ack in IDLE has no effect on `pending`.
- Set/clear collision and reset:
  - Ack id 2 in the same cycle a new edge sets `pending[2]`. Expect the bit to stay 1 and re-assert after GAP.
  - Assert `rst` mid-ASSERT. Expect `interrupt` = 0 and `mtime` = 0 without waiting for a clock edge.
